// File: rtl/led_pattern_sequencer_pkg.sv
// Shared types and defaults for the 4-channel LED pattern sequencer.
// Holds FSM state codes, MODE codes and the 50 MHz / 100 ms tick length.
package led_pattern_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_STOP = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      MODE_WALK    = 2'd0,
      MODE_BLINK   = 2'd1,
      MODE_BREATHE = 2'd2,
      MODE_HEART   = 2'd3
   } mode_e;

   localparam logic [22:0] TICK_CNT_DEF = 23'd5_000_000;

endpackage

// File: rtl/led_pattern_rom.sv
// Pattern table: latched mode and step index in, channel mask and duty level (1..4) out.
module led_pattern_rom
   import led_pattern_sequencer_pkg::*;
(
   input  mode_e       mode_i,
   input  logic [2:0]  step_i,
   output logic [3:0]  mask_o,
   output logic [2:0]  duty_o
);

   always_comb begin
      mask_o = 4'b0000;
      duty_o = 3'd4;
      unique case (mode_i)
         // Walk runs out on steps 0..3 and back on steps 4..7.
         MODE_WALK:    mask_o = step_i[2] ? (4'b1000 >> step_i[1:0]) : (4'b0001 << step_i[1:0]);
         MODE_BLINK:   mask_o = step_i[0] ? 4'b0000 : 4'b1111;
         MODE_BREATHE: begin
            mask_o = 4'b1111;
            duty_o = step_i[2] ? (3'd4 - {1'b0, step_i[1:0]}) : (3'd1 + {1'b0, step_i[1:0]});
         end
         MODE_HEART: begin
            mask_o = (step_i == 3'd0 || step_i == 3'd2) ? 4'b0001 : 4'b0000;
            duty_o = 3'd1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Steps a 4-channel LED bank through an 8-step pattern table on a shared tick counter,
// gating each channel with an end-of-tick aligned duty window.
module led_pattern_sequencer
   import led_pattern_sequencer_pkg::*;
#(
   parameter int unsigned    CW         = 23,
   parameter logic [CW-1:0]  TICK_CNT   = CW'(TICK_CNT_DEF),
   parameter logic [3:0]     STEP_TICKS = 4'd1
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        START,
   input  logic        STOP,
   input  logic [1:0]  MODE,
   output logic [3:0]  LED_OUT,
   output logic        BUSY,
   output logic [2:0]  STEP_IDX
);

   localparam logic [CW-1:0] Q1 = TICK_CNT >> 2;
   localparam logic [CW-1:0] Q2 = Q1 << 1;
   localparam logic [CW-1:0] Q3 = Q1 + Q2;

   state_e          state_q, state_d;
   mode_e           mode_q, mode_d;
   logic [CW-1:0]   count_q, count_d;
   logic [3:0]      tis_q, tis_d;
   logic [2:0]      step_q, step_d;
   logic [3:0]      led_q, led_d;

   logic [3:0]      mask;
   logic [2:0]      duty;
   logic [CW-1:0]   thresh;
   logic            tick, step_end, on;

   led_pattern_rom u_rom (
      .mode_i (mode_q),
      .step_i (step_q),
      .mask_o (mask),
      .duty_o (duty)
   );

   assign tick     = (count_q == TICK_CNT - CW'(1));
   assign step_end = tick && (tis_q == STEP_TICKS - 4'd1);

   // On-window sits at the end of the tick: duty d is on for the last d quarters.
   always_comb begin
      case (duty)
         3'd4:    thresh = '0;
         3'd3:    thresh = Q1;
         3'd2:    thresh = Q2;
         default: thresh = Q3;
      endcase
   end

   assign on = (count_q >= thresh);

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      count_d = count_q;
      tis_d   = tis_q;
      step_d  = step_q;
      led_d   = 4'b0000;
      unique case (state_q)
         ST_IDLE: begin
            count_d = '0;
            tis_d   = '0;
            if (START && !STOP) begin
               state_d = ST_RUN;
               step_d  = 3'd0;
               mode_d  = mode_e'(MODE);
            end
         end
         ST_RUN, ST_STOP: begin
            led_d   = mask & {4{on}};
            count_d = tick ? '0 : count_q + CW'(1);
            if (tick) begin
               tis_d = tis_q + 4'd1;
            end
            if (step_end) begin
               tis_d  = '0;
               step_d = step_q + 3'd1;
               // Mode changes only take effect at the pattern boundary.
               if (step_q == 3'd7) begin
                  mode_d = mode_e'(MODE);
               end
               if (state_q == ST_STOP) begin
                  state_d = ST_IDLE;
               end
            end
            if (state_q == ST_RUN && STOP) begin
               state_d = ST_STOP;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_IDLE;
         mode_q  <= MODE_WALK;
         count_q <= '0;
         tis_q   <= '0;
         step_q  <= '0;
         led_q   <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         count_q <= count_d;
         tis_q   <= tis_d;
         step_q  <= step_d;
         led_q   <= led_d;
      end
   end

   assign LED_OUT  = led_q;
   assign BUSY     = (state_q != ST_IDLE);
   assign STEP_IDX = step_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench: directed scenarios plus random START/STOP/MODE traffic checked every
// cycle against a time-based reference model of the sequencer.
module tb_led_pattern_sequencer;

   localparam int TICK = 8;
   localparam int STPT = 2;
   localparam int STEP_LEN = TICK * STPT;

   logic       CLK = 1'b0;
   logic       RST_N;
   logic       START, STOP;
   logic [1:0] MODE;
   logic [3:0] LED_OUT;
   logic       BUSY;
   logic [2:0] STEP_IDX;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state: elapsed cycles since START drive everything in a run.
   bit         m_active, m_stopping;
   int         m_t;
   logic [1:0] m_mode;
   logic [3:0] m_led;
   logic [2:0] m_idx;

   led_pattern_sequencer #(
      .CW         (23),
      .TICK_CNT   (23'd8),
      .STEP_TICKS (4'd2)
   ) dut (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .START    (START),
      .STOP     (STOP),
      .MODE     (MODE),
      .LED_OUT  (LED_OUT),
      .BUSY     (BUSY),
      .STEP_IDX (STEP_IDX)
   );

   always #5 CLK = ~CLK;

   task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   function automatic logic [3:0] ref_led(input logic [1:0] mode, input int idx, input int c);
      int walk_mask [8] = '{1, 2, 4, 8, 8, 4, 2, 1};
      int breathe   [8] = '{1, 2, 3, 4, 4, 3, 2, 1};
      int mask, duty;
      case (mode)
         2'd0:    begin mask = walk_mask[idx]; duty = 4; end
         2'd1:    begin mask = (idx % 2 == 0) ? 15 : 0; duty = 4; end
         2'd2:    begin mask = 15; duty = breathe[idx]; end
         default: begin mask = (idx == 0 || idx == 2) ? 1 : 0; duty = 1; end
      endcase
      // Lit for the final duty/4 of the tick.
      return (c >= TICK - duty * (TICK / 4)) ? 4'(mask) : 4'b0000;
   endfunction

   task automatic model_reset();
      m_active = 0; m_stopping = 0; m_t = 0; m_mode = 2'd0; m_led = 4'b0; m_idx = 3'd0;
   endtask

   task automatic model_step(input logic st, input logic sp, input logic [1:0] md);
      int idx;
      bit last;
      if (!m_active) begin
         m_led = 4'b0000;
         if (st && !sp) begin
            m_active = 1; m_stopping = 0; m_t = 0; m_mode = md; m_idx = 3'd0;
         end
      end else begin
         idx   = (m_t / STEP_LEN) % 8;
         last  = (m_t % STEP_LEN) == STEP_LEN - 1;
         m_led = ref_led(m_mode, idx, m_t % TICK);
         m_t++;
         m_idx = 3'((m_t / STEP_LEN) % 8);
         if (last && idx == 7) m_mode = md;
         if (last && m_stopping) m_active = 0;
         else if (sp) m_stopping = 1;
      end
   endtask

   task automatic cycle(input logic st, input logic sp, input logic [1:0] md);
      START = st; STOP = sp; MODE = md;
      model_step(st, sp, md);
      @(posedge CLK); #1;
      START = 1'b0; STOP = 1'b0;
      check_val("led", {4'b0, LED_OUT}, {4'b0, m_led});
      check_val("busy", {7'b0, BUSY}, {7'b0, m_active});
      check_val("step", {5'b0, STEP_IDX}, {5'b0, m_idx});
   endtask

   task automatic run(input int n, input logic [1:0] md);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, md);
   endtask

   task automatic stop_and_drain(input logic [1:0] md);
      int guard = 0;
      cycle(1'b0, 1'b1, md);
      while (m_active && guard < 8 * STEP_LEN) begin
         cycle(1'b0, 1'b0, md);
         guard++;
      end
      cycle(1'b0, 1'b0, md);
      check_val("drained_idle", {7'b0, BUSY}, 8'd0);
   endtask

   task automatic async_reset_check();
      #2 RST_N = 1'b0;
      #1;
      check_val("rst_led", {4'b0, LED_OUT}, 8'd0);
      check_val("rst_busy", {7'b0, BUSY}, 8'd0);
      check_val("rst_step", {5'b0, STEP_IDX}, 8'd0);
      model_reset();
      @(negedge CLK);
      RST_N = 1'b1;
   endtask

   initial begin
      RST_N = 1'b0; START = 1'b0; STOP = 1'b0; MODE = 2'd0;
      model_reset();
      #23;
      async_reset_check();
      run(100, 2'd0);

      // Walk: full pattern plus wrap.
      cycle(1'b1, 1'b0, 2'd0);
      run(140, 2'd0);
      stop_and_drain(2'd0);

      // Breathe duty levels.
      cycle(1'b1, 1'b0, 2'd2);
      run(70, 2'd2);
      stop_and_drain(2'd2);

      // Mode latch: blink, switch to walk at step 3, walk begins after the wrap.
      cycle(1'b1, 1'b0, 2'd1);
      run(3 * STEP_LEN, 2'd1);
      run(6 * STEP_LEN, 2'd0);

      // Stop mid-step 4, then restart from step 0.
      while (m_idx != 3'd4) cycle(1'b0, 1'b0, 2'd0);
      run(5, 2'd0);
      stop_and_drain(2'd0);
      check_val("stop_idx", {5'b0, STEP_IDX}, 8'd5);
      cycle(1'b1, 1'b0, 2'd3);
      check_val("restart_idx", {5'b0, STEP_IDX}, 8'd0);
      run(40, 2'd3);

      // START while running is ignored; START+STOP in RUN is a stop.
      cycle(1'b1, 1'b0, 2'd3);
      run(7, 2'd3);
      cycle(1'b1, 1'b1, 2'd3);
      run(2 * STEP_LEN + 4, 2'd3);

      // START+STOP together while idle stays idle.
      cycle(1'b1, 1'b1, 2'd0);
      run(3, 2'd0);

      // Async reset mid-tick while walk is lighting a channel.
      cycle(1'b1, 1'b0, 2'd0);
      run(21, 2'd0);
      async_reset_check();
      run(5, 2'd0);

      // Random traffic.
      MODE = 2'd0;
      for (int i = 0; i < 3000; i++) begin
         logic st, sp;
         logic [1:0] md;
         st = ($urandom_range(0, 99) < 4);
         sp = ($urandom_range(0, 99) < 2);
         md = ($urandom_range(0, 99) < 3) ? 2'($urandom_range(0, 3)) : MODE;
         cycle(st, sp, md);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
- Scheduler for a 4-channel LED bank built on the 100 ms tick / duty-window scheme already used for single-LED blinking.
- Owns one shared tick counter and steps through an 8-step pattern table chosen by MODE.
- Each step sets a per-channel on-mask and a duty level (25/50/75/100 %). The on-window is aligned to the end of each tick period.
- Sits between board push-button/control logic (START/STOP/MODE) and the LED pins.

Parameters:
- TICK_CNT, 23'd5_000_000, clocks per tick (50 MHz x 100 ms); must be divisible by 4.
- STEP_TICKS, 4'd1, ticks per pattern step (1..15).
- CW, 23, tick counter width.

Ports:
- CLK  in  1  system clock, 50 MHz
- RST_N  in  1  reset, asynchronous, active-low
- START  in  1  single-cycle pulse: begin sequencing
- STOP  in  1  single-cycle pulse: finish current step, then idle
- MODE  in  2  pattern select: 0 walk, 1 blink, 2 breathe, 3 heartbeat
- LED_OUT  out  4  registered LED drive, 1 = on
- BUSY  out  1  high in RUN or STOPPING
- STEP_IDX  out  3  current step 0..7

Behaviour:
- Reset (async, RST_N=0): state=IDLE; Count, tick_in_step, STEP_IDX, mode_q all cleared; LED_OUT=4'b0000; BUSY=0.
- States are IDLE, RUN and STOPPING.
  - IDLE --START--> RUN: Count<=0, tick_in_step<=0, STEP_IDX<=0, mode_q<=MODE.
  - RUN --STOP--> STOPPING.
  - STOPPING --step end--> IDLE.
  - START in RUN/STOPPING is ignored.
  - START and STOP in the same cycle: in IDLE, stays IDLE; in RUN, STOP wins.
- Tick counter:
  - Counts 0..TICK_CNT-1 in RUN/STOPPING; held at 0 in IDLE.
  - tick = (Count==TICK_CNT-1); Count wraps to 0 on tick.
- Step counter:
  - tick_in_step increments on tick. Step end = tick && tick_in_step==STEP_TICKS-1.
  - On step end: tick_in_step<=0 and STEP_IDX<=STEP_IDX+1, wrapping 7->0.
  - mode_q re-samples MODE only on the 7->0 wrap, so mid-pattern MODE changes are ignored.
- Pattern table (combinational, mode_q and STEP_IDX -> mask[3:0], duty[2:0] in 1..4):
  - Mode 0 (walk): masks 0001,0010,0100,1000,1000,0100,0010,0001; duty 4.
  - Mode 1 (blink): masks 1111/0000 on even/odd steps; duty 4.
  - Mode 2 (breathe): mask 1111; duty 1,2,3,4,4,3,2,1.
  - Mode 3 (heartbeat): steps 0 and 2 mask 0001, others 0000; duty 1.
- Duty window:
  - Q = TICK_CNT/4, constant. on = (Count >= (4-duty)*Q).
  - Duty 4 is on for the whole tick; duty 1 is on for the last 25 % of each tick.
- LED_OUT:
  - In RUN/STOPPING: LED_OUT <= mask & {4{on}}. Registered, one cycle behind Count.
  - In IDLE: LED_OUT <= 0.
- STOPPING:
  - Completes the current step, then goes to IDLE.
  - LED_OUT is cleared on the cycle after the step-end cycle; STEP_IDX holds its last advanced value.
- BUSY is combinational from state.
- Reset mid-operation aborts immediately to the reset state; no partial-step behaviour is preserved.

Decomposition:
- Shared package/include holds:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_STOP=2'd2;
  - mode codes MODE_WALK..MODE_HEART;
  - the default TICK_CNT for 50 MHz / 100 ms.
- One sub-module, led_pattern_rom: purely combinational, mode_q and STEP_IDX in, mask and duty out.
- Counters, FSM and duty compare stay in the top.

Test Plan (sim overrides TICK_CNT=8, STEP_TICKS=2, so Q=2):
- Reset/idle: hold RST_N low, then release with no START -> LED_OUT=0000, BUSY=0, STEP_IDX=0 for 100 cycles.
- Walk timing: MODE=0, START at cycle 0 -> BUSY=1 from cycle 1; LED_OUT=0001 from cycle 2; STEP_IDX goes 1 after 16 clocks; LED_OUT=0010 one cycle later; the pattern wraps after 128 clocks.
- Breathe duty: MODE=2 -> in step 0 (duty 1), LED_OUT=1111 only while Count>=6, i.e. 2 of every 8 clocks; step 2 (duty 3) gives 6 of 8; step 3 gives 8 of 8.
- Mode latch: start in MODE=1, switch MODE to 0 at step 3 -> blink continues through step 7; walk pattern begins at the step 7->0 wrap.
- Stop: pulse STOP mid-step 4 -> step 4 completes; STEP_IDX=5 and state=IDLE on the cycle after step end; LED_OUT=0000 on the following cycle; a later START restarts at step 0.
- Corner cases:
  - START and STOP together while idle -> stays IDLE.
  - START again while in RUN -> no restart, Count continues.
  - RST_N asserted mid-tick -> all outputs 0 asynchronously.
